vco_loop_filter: RTL and testbench
==================================

// Module: vco_loop_filter
// PURPOSE
//  Digital PI loop filter directly upstream of vco: turns signed phase-error samples into the 8-bit
//  control word that drives vco i_data. Pipelined two-stage update with saturating, anti-windup
//  integrator, valid/ready sample handshake and a lock detector.
// PARAMETERS
//  ERR_W       8     signed phase-error width
//  CTRL_W      8     unsigned control-word width (matches vco i_data)
//  INT_W       16    signed integrator width
//  KP_SHIFT    2     proportional gain = 2^-KP_SHIFT
//  KI_SHIFT    4     integral gain = 2^-KI_SHIFT
//  CTRL_RESET  8'h80 control word after reset (mid-scale)
//  LOCK_TOL    4     |err| <= LOCK_TOL counts as in-lock sample
//  LOCK_COUNT  8     consecutive in-lock samples to assert o_lock
// PORTS
//  i_clk         in   1       single clock, all logic on rising edge
//  i_reset       in   1       synchronous, active-high reset
//  i_err_valid   in   1       error sample valid
//  o_err_ready   out  1       filter can accept a sample
//  i_err         in   ERR_W   signed phase error
//  i_freeze      in   1       sampled with i_err; 1 = do not update integrator
//  o_data        out  CTRL_W  control word to vco i_data
//  o_data_valid  out  1       1-cycle strobe: o_data updated
//  o_sat         out  1       last control word was clamped
//  o_lock        out  1       loop in lock
// BEHAVIOUR
//  Reset: o_data=CTRL_RESET, o_data_valid=0, o_sat=0, o_lock=0, integ=0, lock_cnt=0, state IDLE,
//   o_err_ready=0 while i_reset=1. Reset mid-operation discards any in-flight sample (no strobe).
//  FSM IDLE->MUL->ACC->IDLE. o_err_ready=1 only in IDLE. Accept = i_err_valid & o_err_ready at edge k;
//   i_err/i_freeze captured there. i_err_valid while not ready is ignored (not queued).
//  MUL (edge k+1): register p_term = err >>> KP_SHIFT (arith, floor), sign-extended to INT_W+2.
//  ACC (edge k+2): integ_next = integ + err, clamped to INT_W signed range; integ unchanged if
//   frozen, or if o_sat=1 and err has the same sign as the previous clamp (anti-windup).
//   sum = CTRL_RESET + p_term + (integ_next >>> KI_SHIFT) in INT_W+2 bits; clamp to [0,2^CTRL_W-1];
//   o_sat=1 iff clamped, high/low clamp direction recorded. o_data, o_data_valid=1 registered here.
//  Latency accept->o_data_valid = 2 cycles; o_err_ready high again in same cycle as strobe;
//   max throughput 1 sample / 3 cycles. o_data holds between strobes.
//  Lock: per accepted sample, |err| (|min| = 2^(ERR_W-1)) <= LOCK_TOL -> lock_cnt++ saturating at
//   LOCK_COUNT, else lock_cnt=0. o_lock = (lock_cnt==LOCK_COUNT), updated with o_data_valid.
// STRUCTURE
//  vco_pkg.vh: FSM state localparams (IDLE/MUL/ACC), CTRL_RESET default, clamp helper function.
//  Sub-module vco_lock_detect (err, strobe -> o_lock); PI datapath and FSM in this module.
// TESTING (defaults)
//  Reset 2 cycles -> o_data=0x80, o_data_valid=0, o_sat=0, o_lock=0; o_err_ready=1 next cycle.
//  err=+16 accepted at edge k -> ready=0 k+1..k+2, o_data=0x85 & 1-cycle strobe at k+2.
//  From reset err=-128 -> o_data=0x58 (p=-32, integ=-128, i=-8); o_lock stays 0.
//  Repeat err=+127 -> 13th sample o_data=0xFF, o_sat=1; 14th leaves integ=1651; then err=-64 -> o_data=0xD3, o_sat=0.
//  8x err=+2 -> o_lock=1 on 8th strobe; next err=+5 -> o_lock=0. err=+16 with i_freeze=1 from reset -> 0x84.
//  Accept err=+16, assert i_reset at k+1 -> no strobe, o_data=0x80; valid held while ready=0 not double-taken.

Source files
------------

// File: rtl/vco_loop_filter_pkg.sv
// Shared types, default parameters and the clamp helper for the VCO PI loop filter.
package vco_loop_filter_pkg;

    // Default parameter values
    localparam int ERR_W_DEF      = 8;
    localparam int CTRL_W_DEF     = 8;
    localparam int INT_W_DEF      = 16;
    localparam int KP_SHIFT_DEF   = 2;
    localparam int KI_SHIFT_DEF   = 4;
    localparam int CTRL_RESET_DEF = 128;
    localparam int LOCK_TOL_DEF   = 4;
    localparam int LOCK_COUNT_DEF = 8;

    // Update sequencer: capture sample, register proportional term, accumulate/output
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_ACC  = 2'd2
    } state_e;

    // Result of a range check against [lo, hi]
    typedef enum logic [1:0] {
        CLAMP_NONE = 2'd0,
        CLAMP_HI   = 2'd1,
        CLAMP_LO   = 2'd2
    } clamp_e;

    // Reports whether a signed value lies above, below or inside [lo, hi]
    function automatic clamp_e clamp_dir(input logic signed [31:0] value,
                                         input logic signed [31:0] lo,
                                         input logic signed [31:0] hi);
        clamp_e dir;
        if (value > hi) begin
            dir = CLAMP_HI;
        end else if (value < lo) begin
            dir = CLAMP_LO;
        end else begin
            dir = CLAMP_NONE;
        end
        return dir;
    endfunction

endpackage

// File: rtl/vco_loop_filter_lock_detect.sv
// Lock detector: counts consecutive small-error samples and flags lock once the
// run reaches LOCK_COUNT. Updates only on the output strobe so o_lock moves in
// step with the control word.
module vco_loop_filter_lock_detect
    import vco_loop_filter_pkg::*;
#(
    parameter int ERR_W      = ERR_W_DEF,
    parameter int LOCK_TOL   = LOCK_TOL_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [ERR_W-1:0] i_err,
    input  logic             i_strobe,
    output logic             o_lock
);

    localparam int CNT_W = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_COUNT);
    localparam logic [ERR_W:0]   TOL     = (ERR_W + 1)'(LOCK_TOL);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             lock_q, lock_d;
    logic [ERR_W:0]   err_ext_s;
    logic [ERR_W:0]   mag_s;
    logic             in_lock_s;

    // Magnitude of the error (one extra bit so the most negative value fits) and run counter update
    always_comb begin
        err_ext_s = {i_err[ERR_W-1], i_err};
        if (err_ext_s[ERR_W]) begin
            mag_s = ~err_ext_s + {{ERR_W{1'b0}}, 1'b1};
        end else begin
            mag_s = err_ext_s;
        end
        in_lock_s = (mag_s <= TOL);
        cnt_d     = cnt_q;
        lock_d    = lock_q;
        if (i_strobe) begin
            if (!in_lock_s) begin
                cnt_d = {CNT_W{1'b0}};
            end else if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
            end else begin
                cnt_d = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end
            lock_d = (cnt_d == CNT_MAX);
        end else begin
            cnt_d  = cnt_q;
            lock_d = lock_q;
        end
    end

    // Counter and lock flag registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q  <= {CNT_W{1'b0}};
            lock_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lock_q <= lock_d;
        end
    end

    assign o_lock = lock_q;

endmodule

// File: rtl/vco_loop_filter.sv
// Digital PI loop filter feeding the VCO control word. Each accepted phase-error
// sample walks IDLE -> MUL -> ACC; the control word and a one-cycle strobe are
// registered on the ACC edge. The integrator saturates and stops winding further
// into a clamp that the output is already pinned against.
module vco_loop_filter
    import vco_loop_filter_pkg::*;
#(
    parameter int ERR_W      = ERR_W_DEF,
    parameter int CTRL_W     = CTRL_W_DEF,
    parameter int INT_W      = INT_W_DEF,
    parameter int KP_SHIFT   = KP_SHIFT_DEF,
    parameter int KI_SHIFT   = KI_SHIFT_DEF,
    parameter logic [CTRL_W-1:0] CTRL_RESET = CTRL_W'(CTRL_RESET_DEF),
    parameter int LOCK_TOL   = LOCK_TOL_DEF,
    parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_err_valid,
    output logic                    o_err_ready,
    input  logic signed [ERR_W-1:0] i_err,
    input  logic                    i_freeze,
    output logic [CTRL_W-1:0]       o_data,
    output logic                    o_data_valid,
    output logic                    o_sat,
    output logic                    o_lock
);

    localparam int SUM_W = INT_W + 2;
    localparam logic signed [31:0] INT_MAX32  = (32'sd1 <<< (INT_W - 1)) - 32'sd1;
    localparam logic signed [31:0] INT_MIN32  = -(32'sd1 <<< (INT_W - 1));
    localparam logic signed [31:0] CTRL_MAX32 = (32'sd1 <<< CTRL_W) - 32'sd1;
    localparam logic signed [INT_W-1:0] INT_MAX_W = {1'b0, {(INT_W - 1){1'b1}}};
    localparam logic signed [INT_W-1:0] INT_MIN_W = {1'b1, {(INT_W - 1){1'b0}}};
    localparam logic signed [SUM_W-1:0] CTRL_RESET_EXT = {{(SUM_W - CTRL_W){1'b0}}, CTRL_RESET};

    state_e                  state_q, state_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic                    freeze_q, freeze_d;
    logic signed [SUM_W-1:0] p_term_q, p_term_d;
    logic signed [INT_W-1:0] integ_q, integ_d;
    logic [CTRL_W-1:0]       data_q, data_d;
    logic                    data_valid_q, data_valid_d;
    logic                    sat_q, sat_d;
    logic                    sat_hi_q, sat_hi_d;

    logic                    ready_s;
    logic                    accept_s;
    logic                    strobe_s;
    logic signed [ERR_W-1:0] err_shr_s;
    logic signed [INT_W:0]   integ_sum_s;
    clamp_e                  integ_dir_s;
    logic signed [INT_W-1:0] integ_sat_s;
    logic                    err_pos_s;
    logic                    err_neg_s;
    logic                    hold_s;
    logic signed [INT_W-1:0] integ_next_s;
    logic signed [SUM_W-1:0] integ_ext_s;
    logic signed [SUM_W-1:0] integ_shr_s;
    logic signed [SUM_W-1:0] sum_s;
    clamp_e                  data_dir_s;
    logic [CTRL_W-1:0]       data_next_s;

    assign ready_s  = (state_q == ST_IDLE) & ~i_reset;
    assign accept_s = i_err_valid & ready_s;
    assign strobe_s = (state_q == ST_ACC);

    // PI arithmetic: saturating integrator with anti-windup, then output sum and clamp
    always_comb begin
        err_shr_s   = err_q >>> KP_SHIFT;
        integ_sum_s = {integ_q[INT_W-1], integ_q}
                    + {{(INT_W + 1 - ERR_W){err_q[ERR_W-1]}}, err_q};
        integ_dir_s = clamp_dir({{(31 - INT_W){integ_sum_s[INT_W]}}, integ_sum_s},
                                INT_MIN32, INT_MAX32);
        integ_sat_s = integ_sum_s[INT_W-1:0];
        case (integ_dir_s)
            CLAMP_HI:   integ_sat_s = INT_MAX_W;
            CLAMP_LO:   integ_sat_s = INT_MIN_W;
            CLAMP_NONE: integ_sat_s = integ_sum_s[INT_W-1:0];
            default:    integ_sat_s = integ_sum_s[INT_W-1:0];
        endcase
        // A sample pushing further into the clamp the output already sits on is not integrated
        err_pos_s = ~err_q[ERR_W-1] & (|err_q);
        err_neg_s = err_q[ERR_W-1];
        hold_s    = freeze_q | (sat_q & ((sat_hi_q & err_pos_s) | (~sat_hi_q & err_neg_s)));
        if (hold_s) begin
            integ_next_s = integ_q;
        end else begin
            integ_next_s = integ_sat_s;
        end
        integ_ext_s = {{(SUM_W - INT_W){integ_next_s[INT_W-1]}}, integ_next_s};
        integ_shr_s = integ_ext_s >>> KI_SHIFT;
        sum_s       = CTRL_RESET_EXT + p_term_q + integ_shr_s;
        data_dir_s  = clamp_dir({{(32 - SUM_W){sum_s[SUM_W-1]}}, sum_s}, 32'sd0, CTRL_MAX32);
        data_next_s = sum_s[CTRL_W-1:0];
        case (data_dir_s)
            CLAMP_HI:   data_next_s = {CTRL_W{1'b1}};
            CLAMP_LO:   data_next_s = {CTRL_W{1'b0}};
            CLAMP_NONE: data_next_s = sum_s[CTRL_W-1:0];
            default:    data_next_s = sum_s[CTRL_W-1:0];
        endcase
    end

    // Sequencer next-state and register updates for each pipeline stage
    always_comb begin
        state_d      = state_q;
        err_d        = err_q;
        freeze_d     = freeze_q;
        p_term_d     = p_term_q;
        integ_d      = integ_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        sat_d        = sat_q;
        sat_hi_d     = sat_hi_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    err_d    = i_err;
                    freeze_d = i_freeze;
                    state_d  = ST_MUL;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_MUL: begin
                p_term_d = {{(SUM_W - ERR_W){err_shr_s[ERR_W-1]}}, err_shr_s};
                state_d  = ST_ACC;
            end
            ST_ACC: begin
                integ_d      = integ_next_s;
                data_d       = data_next_s;
                data_valid_d = 1'b1;
                sat_d        = (data_dir_s != CLAMP_NONE);
                sat_hi_d     = (data_dir_s == CLAMP_HI);
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any sample in flight
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q      <= ST_IDLE;
            err_q        <= {ERR_W{1'b0}};
            freeze_q     <= 1'b0;
            p_term_q     <= {SUM_W{1'b0}};
            integ_q      <= {INT_W{1'b0}};
            data_q       <= CTRL_RESET;
            data_valid_q <= 1'b0;
            sat_q        <= 1'b0;
            sat_hi_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            err_q        <= err_d;
            freeze_q     <= freeze_d;
            p_term_q     <= p_term_d;
            integ_q      <= integ_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            sat_q        <= sat_d;
            sat_hi_q     <= sat_hi_d;
        end
    end

    vco_loop_filter_lock_detect #(
        .ERR_W      (ERR_W),
        .LOCK_TOL   (LOCK_TOL),
        .LOCK_COUNT (LOCK_COUNT)
    ) u_lock_detect (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_err    (err_q),
        .i_strobe (strobe_s),
        .o_lock   (o_lock)
    );

    assign o_err_ready  = ready_s;
    assign o_data       = data_q;
    assign o_data_valid = data_valid_q;
    assign o_sat        = sat_q;

endmodule

// File: tb/tb_vco_loop_filter.sv
// Self-checking bench for vco_loop_filter: directed scenarios plus randomized
// samples compared against an arithmetic model of the PI filter.
module tb_vco_loop_filter;

    logic       i_clk = 1'b0;
    logic       i_reset;
    logic       i_err_valid;
    logic       o_err_ready;
    logic [7:0] i_err;
    logic       i_freeze;
    logic [7:0] o_data;
    logic       o_data_valid;
    logic       o_sat;
    logic       o_lock;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;

    // Reference model state
    int m_integ, m_cnt, m_data;
    bit m_sat, m_sat_hi, m_lock;

    // Observations from the last driven sample
    logic [7:0] obs_data;
    logic       obs_sat, obs_lock, obs_ready_strobe, obs_valid_after, obs_ready_early;
    int         obs_lat;

    vco_loop_filter dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_err_valid  (i_err_valid),
        .o_err_ready  (o_err_ready),
        .i_err        (i_err),
        .i_freeze     (i_freeze),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .o_sat        (o_sat),
        .o_lock       (o_lock)
    );

    always #5 i_clk = ~i_clk;

    always @(negedge i_clk) begin
        if (o_data_valid === 1'b1) strobe_cnt <= strobe_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int floor_div(input int a, input int b);
        if (a >= 0) return a / b;
        return -((-a + b - 1) / b);
    endfunction

    task automatic model_reset;
        m_integ = 0; m_cnt = 0; m_data = 128;
        m_sat = 0; m_sat_hi = 0; m_lock = 0;
    endtask

    task automatic model_step(input int err, input bit frz);
        int p, s, mag;
        bit windup;
        p = floor_div(err, 4);
        windup = m_sat && ((m_sat_hi && err > 0) || (!m_sat_hi && err < 0));
        if (!frz && !windup) begin
            m_integ = m_integ + err;
            if (m_integ > 32767) m_integ = 32767;
            if (m_integ < -32768) m_integ = -32768;
        end
        s = 128 + p + floor_div(m_integ, 16);
        if (s > 255) begin
            m_data = 255; m_sat = 1; m_sat_hi = 1;
        end else if (s < 0) begin
            m_data = 0; m_sat = 1; m_sat_hi = 0;
        end else begin
            m_data = s; m_sat = 0;
        end
        mag = (err < 0) ? -err : err;
        if (mag <= 4) m_cnt = (m_cnt >= 8) ? 8 : m_cnt + 1;
        else m_cnt = 0;
        m_lock = (m_cnt == 8);
    endtask

    task automatic do_reset;
        i_err_valid = 1'b0; i_err = 8'd0; i_freeze = 1'b0;
        @(negedge i_clk); i_reset = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk); i_reset = 1'b0;
        model_reset();
    endtask

    // Offer one sample, wait for its strobe and record what the DUT showed
    task automatic drive_sample(input int err, input bit frz, input bit hold_valid);
        int  waited;
        bit  got;
        obs_data = 8'hxx; obs_sat = 1'bx; obs_lock = 1'bx;
        obs_ready_strobe = 1'bx; obs_valid_after = 1'bx;
        obs_ready_early = 1'b0; obs_lat = 0;
        @(negedge i_clk);
        waited = 0;
        while (o_err_ready !== 1'b1 && waited < 20) begin
            @(negedge i_clk); waited++;
        end
        if (o_err_ready !== 1'b1) return;
        i_err_valid = 1'b1; i_err = 8'(err); i_freeze = frz;
        @(posedge i_clk);
        #1;
        if (!hold_valid) i_err_valid = 1'b0;
        got = 0;
        for (int c = 0; c < 8 && !got; c++) begin
            @(negedge i_clk);
            if (o_data_valid === 1'b1) got = 1;
            else begin
                if (o_err_ready !== 1'b0) obs_ready_early = 1'b1;
                @(posedge i_clk);
                obs_lat++;
            end
        end
        i_err_valid = 1'b0;
        if (!got) return;
        obs_data = o_data; obs_sat = o_sat; obs_lock = o_lock; obs_ready_strobe = o_err_ready;
        model_step(err, frz);
        @(posedge i_clk);
        @(negedge i_clk);
        obs_valid_after = o_data_valid;
    endtask

    task automatic test_reset;
        i_err_valid = 1'b0; i_err = 8'd0; i_freeze = 1'b0;
        @(negedge i_clk); i_reset = 1'b1;
        @(negedge i_clk);
        n_checks++; if (o_err_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", o_err_ready); end
        n_checks++; if (o_data !== 8'h80) begin n_fail++; $display("FAIL reset_data: got %h want 80", o_data); end
        n_checks++; if (o_data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", o_data_valid); end
        n_checks++; if (o_sat !== 1'b0 || o_lock !== 1'b0) begin n_fail++; $display("FAIL reset_sat_lock: got %b%b want 00", o_sat, o_lock); end
        @(negedge i_clk); i_reset = 1'b0;
        model_reset();
        @(negedge i_clk);
        n_checks++; if (o_err_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_reset: got %b want 1", o_err_ready); end
    endtask

    task automatic test_latency;
        do_reset();
        drive_sample(16, 1'b0, 1'b0);
        n_checks++; if (obs_data !== 8'h85) begin n_fail++; $display("FAIL lat_data: got %h want 85", obs_data); end
        n_checks++; if (obs_lat !== 2) begin n_fail++; $display("FAIL lat_cycles: got %0d want 2", obs_lat); end
        n_checks++; if (obs_ready_early !== 1'b0) begin n_fail++; $display("FAIL lat_ready_busy: got %b want 0", obs_ready_early); end
        n_checks++; if (obs_ready_strobe !== 1'b1) begin n_fail++; $display("FAIL lat_ready_strobe: got %b want 1", obs_ready_strobe); end
        n_checks++; if (obs_valid_after !== 1'b0) begin n_fail++; $display("FAIL lat_strobe_width: got %b want 0", obs_valid_after); end
        n_checks++; if (obs_sat !== 1'b0) begin n_fail++; $display("FAIL lat_sat: got %b want 0", obs_sat); end
    endtask

    task automatic test_neg_full;
        do_reset();
        drive_sample(-128, 1'b0, 1'b0);
        n_checks++; if (obs_data !== 8'h58) begin n_fail++; $display("FAIL negfull_data: got %h want 58", obs_data); end
        n_checks++; if (obs_lock !== 1'b0 || obs_sat !== 1'b0) begin n_fail++; $display("FAIL negfull_flags: got lock %b sat %b want 0 0", obs_lock, obs_sat); end
    endtask

    task automatic test_saturation;
        do_reset();
        for (int i = 1; i <= 14; i++) begin
            drive_sample(127, 1'b0, 1'b0);
            n_checks++;
            if (obs_data !== 8'(m_data) || obs_sat !== m_sat) begin
                n_fail++; $display("FAIL sat_step%0d: got %h/%b want %h/%b", i, obs_data, obs_sat, m_data, m_sat);
            end
            if (i == 13) begin
                n_checks++; if (obs_data !== 8'hFF || obs_sat !== 1'b1) begin n_fail++; $display("FAIL sat_clamp13: got %h/%b want ff/1", obs_data, obs_sat); end
            end
        end
        drive_sample(-64, 1'b0, 1'b0);
        n_checks++; if (obs_data !== 8'hD3 || obs_sat !== 1'b0) begin n_fail++; $display("FAIL sat_antiwindup: got %h/%b want d3/0", obs_data, obs_sat); end
    endtask

    task automatic test_lock;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            drive_sample(2, 1'b0, 1'b0);
            n_checks++;
            if (obs_lock !== (i == 8) || obs_data !== 8'(m_data)) begin
                n_fail++; $display("FAIL lock_step%0d: got lock %b data %h want %b %h", i, obs_lock, obs_data, (i == 8), m_data);
            end
        end
        drive_sample(5, 1'b0, 1'b0);
        n_checks++; if (obs_lock !== 1'b0) begin n_fail++; $display("FAIL lock_drop: got %b want 0", obs_lock); end
    endtask

    task automatic test_freeze;
        do_reset();
        drive_sample(16, 1'b1, 1'b0);
        n_checks++; if (obs_data !== 8'h84) begin n_fail++; $display("FAIL freeze_data: got %h want 84", obs_data); end
        drive_sample(16, 1'b0, 1'b0);
        n_checks++; if (obs_data !== 8'h85) begin n_fail++; $display("FAIL freeze_resume: got %h want 85", obs_data); end
    endtask

    task automatic test_reset_midop;
        int base;
        do_reset();
        base = strobe_cnt;
        @(negedge i_clk);
        i_err_valid = 1'b1; i_err = 8'd16; i_freeze = 1'b0;
        @(posedge i_clk);
        #1 i_err_valid = 1'b0;
        @(negedge i_clk); i_reset = 1'b1;
        @(negedge i_clk); i_reset = 1'b0;
        model_reset();
        repeat (6) @(negedge i_clk);
        #1;
        n_checks++; if (strobe_cnt !== base) begin n_fail++; $display("FAIL midreset_strobes: got %0d want 0", strobe_cnt - base); end
        n_checks++; if (o_data !== 8'h80 || o_sat !== 1'b0) begin n_fail++; $display("FAIL midreset_data: got %h/%b want 80/0", o_data, o_sat); end
        drive_sample(16, 1'b0, 1'b0);
        n_checks++; if (obs_data !== 8'h85) begin n_fail++; $display("FAIL midreset_next: got %h want 85", obs_data); end
    endtask

    task automatic test_back_to_back;
        int base;
        do_reset();
        base = strobe_cnt;
        drive_sample(16, 1'b0, 1'b1);
        repeat (6) @(negedge i_clk);
        #1;
        n_checks++; if (strobe_cnt - base !== 1) begin n_fail++; $display("FAIL hold_single_take: got %0d strobes want 1", strobe_cnt - base); end
        n_checks++; if (o_data !== 8'h85) begin n_fail++; $display("FAIL hold_data: got %h want 85", o_data); end
        drive_sample(-16, 1'b0, 1'b0);
        n_checks++; if (obs_data !== 8'(m_data)) begin n_fail++; $display("FAIL b2b_second: got %h want %h", obs_data, m_data); end
    endtask

    task automatic test_random;
        int e;
        bit frz;
        do_reset();
        for (int i = 0; i < 240; i++) begin
            if (((i / 40) % 2) == 1 && $urandom_range(0, 9) != 0) e = int'($urandom_range(0, 12)) - 6;
            else e = int'($urandom_range(0, 255)) - 128;
            frz = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
            drive_sample(e, frz, 1'b0);
            n_checks++;
            if (obs_data !== 8'(m_data) || obs_sat !== m_sat || obs_lock !== m_lock) begin
                n_fail++;
                $display("FAIL rand%0d err %0d frz %b: got %h/%b/%b want %h/%b/%b", i, e, frz,
                         obs_data, obs_sat, obs_lock, m_data, m_sat, m_lock);
            end
        end
    endtask

    initial begin
        i_reset = 1'b1; i_err_valid = 1'b0; i_err = 8'd0; i_freeze = 1'b0;
        test_reset();
        test_latency();
        test_neg_full();
        test_saturation();
        test_lock();
        test_freeze();
        test_reset_midop();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
